// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Instruction field bit positions
  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int OP_HI    = 27;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 25;
  localparam int FUNCT_LO = 20;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

  // Sequential step and architectural PC read offset
  localparam int PC_INC      = 4;
  localparam int PC_READ_OFS = 8;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ack, holds the word in the
// instruction register until control consumes it, then applies any redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd,
  output logic [ADDR_W-1:0] pc_plus8
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_RST     = RESET_PC & ALIGN_MASK;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;    // next address to fetch
  logic [ADDR_W-1:0] ipc_q, ipc_d;  // address of the presented instruction
  logic [31:0]       ir_q, ir_d;

  // State, PC and IR registers; reset abandons any in-flight request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      ipc_q   <= PC_RST;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic: ack only matters in REQ, redirect only on an unstalled HOLD
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_q + ADDR_W'(PC_INC);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          if (pc_src) pc_d = branch_target & ALIGN_MASK;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded straight from registered state
  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = ir_q;
  assign cond        = ir_q[COND_HI:COND_LO];
  assign op          = ir_q[OP_HI:OP_LO];
  assign funct       = ir_q[FUNCT_HI:FUNCT_LO];
  assign rd          = ir_q[RD_HI:RD_LO];
  assign pc_plus8    = ipc_q + ADDR_W'(PC_READ_OFS);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances share stimulus, the second
// starts at the top of the address space to exercise PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;

  logic        req_a, req_b, vld_a, vld_b;
  logic [31:0] addr_a, addr_b, instr_a, instr_b, p8_a, p8_b;
  logic [3:0]  cond_a, cond_b, rd_a, rd_b;
  logic [1:0]  op_a, op_b;
  logic [5:0]  funct_a, funct_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .imem_req(req_a), .imem_addr(addr_a),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .pc_src(pc_src), .branch_target(branch_target), .instr_valid(vld_a),
    .instr(instr_a), .cond(cond_a), .op(op_a), .funct(funct_a), .rd(rd_a),
    .pc_plus8(p8_a)
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset), .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .pc_src(pc_src), .branch_target(branch_target), .instr_valid(vld_b),
    .instr(instr_b), .cond(cond_b), .op(op_b), .funct(funct_b), .rd(rd_b),
    .pc_plus8(p8_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; pc_src = 1'b0; branch_target = '0;

    // Reset state
    tick(); tick();
    chk("rst_req", 32'(req_a), 32'd0);
    chk("rst_vld", 32'(vld_a), 32'd0);
    chk("rst_instr", instr_a, 32'h0);
    chk("rst_pc8", p8_a, 32'h8);
    chk("rst_pc8_wrap", p8_b, 32'h4);

    // Release into always-ack memory; this cycle is IDLE
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hE3A0_1005;
    chk("idle_req", 32'(req_a), 32'd0);
    tick();
    chk("req1_req", 32'(req_a), 32'd1);
    chk("req1_addr", addr_a, 32'h0);
    chk("req1_vld", 32'(vld_a), 32'd0);
    chk("req1_addr_b", addr_b, 32'hFFFF_FFFC);
    tick();
    chk("hold1_vld", 32'(vld_a), 32'd1);
    chk("hold1_req", 32'(req_a), 32'd0);
    chk("hold1_cond", 32'(cond_a), 32'hE);
    chk("hold1_op", 32'(op_a), 32'h0);
    chk("hold1_funct", 32'(funct_a), 32'h3A);
    chk("hold1_rd", 32'(rd_a), 32'h1);
    chk("hold1_pc8", p8_a, 32'h8);
    chk("hold1_pc8_b", p8_b, 32'h4);

    // Stall for 5 cycles with a redirect and stray ack that must be ignored
    stall = 1'b1; pc_src = 1'b1; branch_target = 32'h0000_0200;
    imem_rdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_vld", 32'(vld_a), 32'd1);
      chk("stall_req", 32'(req_a), 32'd0);
      chk("stall_instr", instr_a, 32'hE3A0_1005);
    end

    // Drop stall, no redirect: next address is sequential, wait-state memory
    stall = 1'b0; pc_src = 1'b0; imem_ack = 1'b0;
    tick();
    chk("seq_req", 32'(req_a), 32'd1);
    chk("seq_addr", addr_a, 32'h4);
    chk("wrap_addr_b", addr_b, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req", 32'(req_a), 32'd1);
      chk("wait_addr", addr_a, 32'h4);
      chk("wait_vld", 32'(vld_a), 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    chk("wait_done_vld", 32'(vld_a), 32'd1);
    chk("wait_done_instr", instr_a, 32'h1234_5678);
    chk("wait_done_pc8", p8_a, 32'hC);

    // Taken redirect on consumption; target low bits dropped
    pc_src = 1'b1; branch_target = 32'h0000_0103;
    tick();
    chk("br_req", 32'(req_a), 32'd1);
    chk("br_addr", addr_a, 32'h0000_0100);
    pc_src = 1'b0; imem_rdata = 32'hAAAA_5555;
    tick();
    chk("br_vld", 32'(vld_a), 32'd1);
    chk("br_pc8", p8_a, 32'h0000_0108);
    tick();
    chk("br_next_addr", addr_a, 32'h0000_0104);

    // Reset in REQ, ack arrives the next cycle and must be ignored
    imem_ack = 1'b0; reset = 1'b1;
    tick();
    chk("mid_rst_req", 32'(req_a), 32'd0);
    chk("mid_rst_vld", 32'(vld_a), 32'd0);
    chk("mid_rst_instr", instr_a, 32'h0);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("late_ack_vld", 32'(vld_a), 32'd0);
    chk("refetch_req", 32'(req_a), 32'd1);
    chk("refetch_addr", addr_a, 32'h0);
    tick();
    chk("refetch_vld", 32'(vld_a), 32'd1);
    chk("refetch_instr", instr_a, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
